univ_shreg: RTL and testbench
=============================

# univ_shreg

Parametrised universal shift register, generalising the team's fixed 6-bit serial-in/parallel-out register. It supports:
- configurable width;
- hold, shift-right, shift-left, parallel load, rotate-right, rotate-left and synchronous clear;
- a shift counter that flags each completed word.

It sits between serial links and parallel datapaths, serving as a SIPO, PISO or rotator depending on `mode`.

## Interface
- `WIDTH`, default 6, register width in bits; legal range is 2 or more.
- `CW`, default `$clog2(WIDTH+1)`, width of the shift counter (derived; do not override).
- `clk`, in, 1, clock; all state updates on the rising edge.
- `rst`, in, 1, reset; asynchronous, active-high.
- `en`, in, 1, clock enable; when low, all state holds regardless of `mode`.
- `mode`, in, 3, operation select (see Operation).
- `sin_r`, in, 1, serial input entering at the MSB on shift-right.
- `sin_l`, in, 1, serial input entering at the LSB on shift-left.
- `d`, in, WIDTH, parallel load data.
- `q`, out, WIDTH, register contents.
- `sout_r`, out, 1, equals `q[0]` (bit leaving on shift-right); combinational from `q`.
- `sout_l`, out, 1, equals `q[WIDTH-1]` (bit leaving on shift-left); combinational from `q`.
- `cnt`, out, CW, number of shift/rotate operations since the last load, clear, reset or word completion.
- `word_done`, out, 1, registered one-cycle pulse marking that WIDTH shifts/rotates have completed.

## Operation
- Mode encoding, applied on the rising edge with `en` = 1:
  - 000: hold.
  - 001: shift right, `q <= {sin_r, q[WIDTH-1:1]}`.
  - 010: shift left, `q <= {q[WIDTH-2:0], sin_l}`.
  - 011: load, `q <= d`.
  - 100: rotate right, `q <= {q[0], q[WIDTH-1:1]}`.
  - 101: rotate left, `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
  - 110: synchronous clear, `q <= 0`.
  - 111: reserved; behaves exactly as hold.
- Counter, for shift/rotate modes (001, 010, 100, 101) with `en` = 1:
  - If `cnt == WIDTH-1`, then `cnt <= 0` and `word_done <= 1`.
  - Otherwise `cnt <= cnt+1` and `word_done <= 0`.
- Load (011) or clear (110) with `en` = 1: `cnt <= 0` and `word_done <= 0`. This abandons any partial word with no pulse.
- Hold or reserved mode with `en` = 1: `cnt` holds and `word_done <= 0`.
- `en` = 0: `q` and `cnt` hold, and `word_done <= 0`. The pulse never stretches.
- Mixing shift directions or shift and rotate within one word is legal. Every shift/rotate counts toward the word.
- Counter never exceeds WIDTH-1. `cnt` values at or above WIDTH are unreachable.

## Timing
- Reset (`rst` = 1, asynchronous, takes effect without a clock edge):
  - `q` = 0, `cnt` = 0, `word_done` = 0.
  - `sout_r` = `sout_l` = 0.
- Reset wins over every other input while asserted.
- After `rst` deasserts, the first active edge applies the selected mode normally.
- Reset mid-word: the partial word is discarded and no `word_done` pulse is produced.
- Latency:
  - `q` reflects the operation one edge after it is sampled.
  - `sout_r`/`sout_l` follow `q` with zero added latency.
- `word_done` rises on the same edge that performs the WIDTH-th shift/rotate, and is high for exactly one cycle.
- Continuous shifting produces one pulse every WIDTH cycles, with no gap cycle.
- Inputs `sin_r`, `sin_l`, `d` and `mode` are sampled only at the rising edge and must be stable around it.

## Test plan
- **SIPO right shift.** WIDTH=6, reset, then `mode`=001, `en`=1, `sin_r` = 0,1,0,0,1,0 on six consecutive edges.
  - Required: `q` = 6'b010010.
  - Required: `cnt` steps 1..5 then 0.
  - Required: `word_done` high only in the cycle after the 6th edge.
- **PISO left shift.** Load `d` = 6'b101100, then 6 edges of `mode`=010 with `sin_l`=0.
  - Required: `sout_l` sequence, sampled before each edge, is 1,0,1,1,0,0.
  - Required: final `q` = 0 and one `word_done` pulse.
- **Rotate.** Load 6'b100001.
  - One rotate-left gives 6'b000011.
  - Reload, then one rotate-right gives 6'b110000.
  - Six rotate-rights return 6'b100001 with a `word_done` pulse.
- **Enable and reserved mode.** After 3 right shifts, drive `en`=0 with `mode`=001 for 4 edges, then `mode`=111 with `en`=1 for 2 edges.
  - Required: `q` unchanged, `cnt` = 3, `word_done` = 0 throughout.
- **Abandon partial word.** After 5 shifts (`cnt`=5), apply load with `d`=6'b111111.
  - Required: `cnt` = 0, no `word_done`, `q` = 6'b111111.
  - Repeat using clear: `q` = 0, `cnt` = 0.
- **Async reset mid-operation.** Assert `rst` between edges after 3 shifts.
  - Required: `q`, `cnt` and `word_done` go to 0 immediately, without a clock edge.
  - After release, 6 further shifts produce exactly one `word_done`.
- **Width generality.** Rerun scenario 1 with WIDTH=8 and 8 serial bits.
  - Required: `word_done` pulses after the 8th edge.
  - Required: `cnt` wraps from 7 to 0.

Source files
------------

// File: rtl/univ_shreg_if.sv
// Bundles the control, data and status signals of one univ_shreg instance.
// The master drives mode/data, and the slave (the register) returns its state.
interface univ_shreg_if #(
    parameter int WIDTH = 6,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             word_done;

    modport master (
        output en, mode, sin_r, sin_l, d,
        input  q, sout_r, sout_l, cnt, word_done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, d,
        output q, sout_r, sout_l, cnt, word_done
    );
endinterface

// File: rtl/univ_shreg.sv
// Universal shift register: shift/rotate/load/clear, with a shift counter
// that pulses word_done on every WIDTH-th shift or rotate.
module univ_shreg #(
    parameter int WIDTH = 6,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input logic        clk,
    input logic        rst,
    univ_shreg_if.slave bus
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_p0;
    logic [CW-1:0]    cnt_p0;
    logic             done_p0;
    logic             is_shift;
    logic             is_restart;

    always_comb begin
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (bus.mode)
            3'b001, 3'b010, 3'b100, 3'b101: is_shift   = 1'b1;
            3'b011, 3'b110:                 is_restart = 1'b1;
            default: ;
        endcase
    end

    // stage p0: register contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_p0 <= '0;
        end else if (bus.en) begin
            case (bus.mode)
                3'b001:  q_p0 <= {bus.sin_r, q_p0[WIDTH-1:1]};
                3'b010:  q_p0 <= {q_p0[WIDTH-2:0], bus.sin_l};
                3'b011:  q_p0 <= bus.d;
                3'b100:  q_p0 <= {q_p0[0], q_p0[WIDTH-1:1]};
                3'b101:  q_p0 <= {q_p0[WIDTH-2:0], q_p0[WIDTH-1]};
                3'b110:  q_p0 <= '0;
                default: q_p0 <= q_p0;
            endcase
        end
    end

    // stage p0: word counter; the pulse defaults low so it never stretches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0  <= '0;
            done_p0 <= 1'b0;
        end else begin
            done_p0 <= 1'b0;
            if (bus.en && is_shift) begin
                if (cnt_p0 == LAST) begin
                    cnt_p0  <= '0;
                    done_p0 <= 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + CW'(1);
                end
            end else if (bus.en && is_restart) begin
                cnt_p0 <= '0;
            end
        end
    end

    assign bus.q         = q_p0;
    assign bus.sout_r    = q_p0[0];
    assign bus.sout_l    = q_p0[WIDTH-1];
    assign bus.cnt       = cnt_p0;
    assign bus.word_done = done_p0;
endmodule

// File: tb/tb_univ_shreg.sv
// Directed bench for univ_shreg at WIDTH=6 and WIDTH=8 with hand-computed expectations.
module tb_univ_shreg;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   pulses;

    univ_shreg_if #(.WIDTH(6)) b6 ();
    univ_shreg_if #(.WIDTH(8)) b8 ();

    univ_shreg #(.WIDTH(6)) dut6 (.clk(clk), .rst(rst), .bus(b6));
    univ_shreg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step6(input logic e, input logic [2:0] m, input logic sr,
                         input logic sl, input logic [5:0] dd);
        b6.en = e; b6.mode = m; b6.sin_r = sr; b6.sin_l = sl; b6.d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic [2:0] m, input logic sr);
        b8.en = 1'b1; b8.mode = m; b8.sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] bits6;
        logic [5:0] sl_exp;
        logic [7:0] bits8;
        checks = 0; failures = 0;
        rst = 1'b0;
        b6.en = 1'b0; b6.mode = 3'b000; b6.sin_r = 1'b0; b6.sin_l = 1'b0; b6.d = '0;
        b8.en = 1'b0; b8.mode = 3'b000; b8.sin_r = 1'b0; b8.sin_l = 1'b0; b8.d = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_q", 32'(b6.q), 32'h0);
        check("rst_cnt", 32'(b6.cnt), 32'h0);
        check("rst_wd", 32'(b6.word_done), 32'h0);
        check("rst_sout_r", 32'(b6.sout_r), 32'h0);
        check("rst_sout_l", 32'(b6.sout_l), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // SIPO right shift: bits 0,1,0,0,1,0 enter at the MSB
        bits6 = 6'b010010;
        for (int i = 0; i < 6; i++) begin
            step6(1'b1, 3'b001, bits6[i], 1'b0, 6'h00);
            check("sipo_cnt", 32'(b6.cnt), 32'((i + 1) % 6));
            check("sipo_wd", 32'(b6.word_done), 32'(i == 5));
        end
        check("sipo_q", 32'(b6.q), 32'h12);
        check("sipo_sout_r", 32'(b6.sout_r), 32'h0);
        step6(1'b1, 3'b000, 1'b0, 1'b0, 6'h00);
        check("hold_wd_drop", 32'(b6.word_done), 32'h0);
        check("hold_q", 32'(b6.q), 32'h12);

        // PISO left shift of 101100
        step6(1'b1, 3'b011, 1'b0, 1'b0, 6'b101100);
        check("load_q", 32'(b6.q), 32'h2c);
        check("load_cnt", 32'(b6.cnt), 32'h0);
        sl_exp = 6'b001101;
        for (int i = 0; i < 6; i++) begin
            check("piso_sout_l", 32'(b6.sout_l), 32'(sl_exp[i]));
            step6(1'b1, 3'b010, 1'b0, 1'b0, 6'h00);
            check("piso_wd", 32'(b6.word_done), 32'(i == 5));
        end
        check("piso_q", 32'(b6.q), 32'h0);

        // Rotates
        step6(1'b1, 3'b011, 1'b0, 1'b0, 6'b100001);
        step6(1'b1, 3'b101, 1'b0, 1'b0, 6'h00);
        check("rotl_q", 32'(b6.q), 32'b000011);
        check("rotl_cnt", 32'(b6.cnt), 32'h1);
        step6(1'b1, 3'b011, 1'b0, 1'b0, 6'b100001);
        step6(1'b1, 3'b100, 1'b0, 1'b0, 6'h00);
        check("rotr_q", 32'(b6.q), 32'b110000);
        step6(1'b1, 3'b011, 1'b0, 1'b0, 6'b100001);
        for (int i = 0; i < 6; i++) begin
            step6(1'b1, 3'b100, 1'b0, 1'b0, 6'h00);
            check("rot6_wd", 32'(b6.word_done), 32'(i == 5));
        end
        check("rot6_q", 32'(b6.q), 32'b100001);

        // Enable low and reserved mode hold everything
        for (int i = 0; i < 3; i++) step6(1'b1, 3'b001, 1'b1, 1'b0, 6'h00);
        check("pre_en_q", 32'(b6.q), 32'b111100);
        check("pre_en_cnt", 32'(b6.cnt), 32'h3);
        for (int i = 0; i < 4; i++) begin
            step6(1'b0, 3'b001, 1'b0, 1'b0, 6'h00);
            check("en0_q", 32'(b6.q), 32'b111100);
            check("en0_cnt", 32'(b6.cnt), 32'h3);
            check("en0_wd", 32'(b6.word_done), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            step6(1'b1, 3'b111, 1'b1, 1'b1, 6'h3f);
            check("rsv_q", 32'(b6.q), 32'b111100);
            check("rsv_cnt", 32'(b6.cnt), 32'h3);
            check("rsv_wd", 32'(b6.word_done), 32'h0);
        end
        for (int i = 0; i < 3; i++) step6(1'b1, 3'b001, 1'b0, 1'b0, 6'h00);
        check("finish_wd", 32'(b6.word_done), 32'h1);
        check("finish_q", 32'(b6.q), 32'b000111);
        step6(1'b0, 3'b001, 1'b1, 1'b0, 6'h00);
        check("en0_pulse_drop", 32'(b6.word_done), 32'h0);
        check("en0_pulse_q", 32'(b6.q), 32'b000111);

        // Abandon a partial word with load, then with clear
        for (int i = 0; i < 5; i++) step6(1'b1, 3'b001, 1'b1, 1'b0, 6'h00);
        check("part_cnt", 32'(b6.cnt), 32'h5);
        check("part_q", 32'(b6.q), 32'b111110);
        step6(1'b1, 3'b011, 1'b0, 1'b0, 6'h3f);
        check("abload_q", 32'(b6.q), 32'h3f);
        check("abload_cnt", 32'(b6.cnt), 32'h0);
        check("abload_wd", 32'(b6.word_done), 32'h0);
        for (int i = 0; i < 5; i++) step6(1'b1, 3'b001, 1'b0, 1'b0, 6'h00);
        check("part2_cnt", 32'(b6.cnt), 32'h5);
        check("part2_q", 32'(b6.q), 32'b000001);
        step6(1'b1, 3'b110, 1'b0, 1'b0, 6'h3f);
        check("abclr_q", 32'(b6.q), 32'h0);
        check("abclr_cnt", 32'(b6.cnt), 32'h0);
        check("abclr_wd", 32'(b6.word_done), 32'h0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step6(1'b1, 3'b001, 1'b1, 1'b0, 6'h00);
        check("prerst_q", 32'(b6.q), 32'b111000);
        #2 rst = 1'b1;
        #1;
        check("arst_q", 32'(b6.q), 32'h0);
        check("arst_cnt", 32'(b6.cnt), 32'h0);
        check("arst_wd", 32'(b6.word_done), 32'h0);
        check("arst_sout_l", 32'(b6.sout_l), 32'h0);
        #2 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step6(1'b1, 3'b001, 1'b1, 1'b0, 6'h00);
            if (b6.word_done) pulses++;
            check("post_rst_cnt", 32'(b6.cnt), 32'((i + 1) % 6));
        end
        check("post_rst_pulses", 32'(pulses), 32'h1);
        check("post_rst_q", 32'(b6.q), 32'h3f);
        for (int i = 0; i < 6; i++) begin
            step6(1'b1, 3'b010, 1'b0, 1'b0, 6'h00);
            check("back2back_wd", 32'(b6.word_done), 32'(i == 5));
        end
        b6.en = 1'b0;

        // Width generality: 8-bit SIPO, bits 1,0,1,1,0,0,1,0
        bits8 = 8'b01001101;
        for (int i = 0; i < 8; i++) begin
            step8(3'b001, bits8[i]);
            check("w8_cnt", 32'(b8.cnt), 32'((i + 1) % 8));
            check("w8_wd", 32'(b8.word_done), 32'(i == 7));
        end
        check("w8_q", 32'(b8.q), 32'h4d);
        step8(3'b000, 1'b0);
        check("w8_wd_drop", 32'(b8.word_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
